seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 clk  input  1  clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 go  input  1  start request from the calc-system control unit's go_div; level, held high through the DIVGO and DWAIT states.
REQ-005 dividend  input  WIDTH  unsigned dividend; sampled only on the start edge.
REQ-006 divisor  input  WIDTH  unsigned divisor; sampled only on the start edge.
REQ-007 quotient  output  WIDTH  registered quotient result.
REQ-008 remainder  output  WIDTH  registered remainder result.
REQ-009 done  output  1  registered; high for exactly one cycle when the result is valid; feeds DoneDIV.
REQ-010 busy  output  1  registered; high from the start edge until the edge that enters DONE.
REQ-011 div_err  output  1  registered; set for a divide by zero, held with the result.

Function
REQ-012 The block SHALL implement states IDLE, ITER and DONE.
REQ-013 The block SHALL keep an internal armed flag; armed is set on any edge where go=0 and cleared on every start edge.
REQ-014 Start edge: in IDLE with go=1 and armed=1, the block SHALL capture dividend and divisor, clear the partial remainder, clear armed and set busy.
REQ-015 On a start edge with divisor!=0, the block SHALL load the iteration counter with WIDTH-1 and enter ITER.
REQ-016 On a start edge with divisor==0, the block SHALL enter DONE directly with quotient={WIDTH{1}}, remainder=dividend and div_err=1.
REQ-017 Each ITER edge SHALL perform one unsigned restoring step:
- shift {rem, dvd} left by 1;
- if the shifted rem >= divisor, subtract divisor and set the new quotient LSB to 1, else set it to 0.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide so that the compare and subtract cannot overflow.
REQ-019 The ITER edge with counter==0 SHALL enter DONE; every other ITER edge SHALL decrement the counter.
REQ-020 Latency: done SHALL be high in the cycle after edge E0+WIDTH, where E0 is the start edge.
REQ-021 Latency for a zero divisor: done SHALL be high in the cycle after E0.
REQ-022 The edge entering DONE SHALL write quotient, remainder and div_err (div_err=0 when divisor!=0) and clear busy.
REQ-023 The results written on that edge SHALL hold until the next edge that enters DONE.
REQ-024 DONE SHALL last exactly one cycle and then return unconditionally to IDLE; done SHALL be high only in DONE.
REQ-025 go held high continuously SHALL NOT restart the block; a new start requires go=0 on at least one edge after the previous start.
REQ-026 Changes on dividend and divisor while in ITER or DONE SHALL have no effect on the operation in progress.
REQ-027 go falling while in ITER SHALL NOT abort; the operation SHALL complete and pulse done.

Reset
REQ-028 While rst=1, the block SHALL force state IDLE, clear the counter and all internal registers, set armed=1, and drive quotient=0, remainder=0, done=0, busy=0 and div_err=0.
REQ-029 Reset asserted mid-ITER SHALL abandon the operation with no done pulse.
REQ-030 After reset, the first edge with go=1 SHALL start a new operation.

Verification (WIDTH=32)
REQ-031 dividend=100, divisor=7, go pulsed -> done in the cycle after E0+32; quotient=14, remainder=2, div_err=0; busy high for 32 cycles.
REQ-032 dividend=5, divisor=0 -> done in the cycle after E0; quotient=0xFFFFFFFF, remainder=5, div_err=1.
REQ-033 Boundary operands:
- 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0;
- 3/10 -> quotient=0, remainder=3;
- 0/9 -> quotient=0, remainder=0.
REQ-034 go held high for 100 cycles with 100/7 -> exactly one done pulse; dropping go for 1 cycle then raising it -> a second operation with a second done pulse.
REQ-035 rst asserted at ITER cycle 10 of 100/7 -> all outputs 0 immediately with no done pulse; a following 50/6 run -> quotient=8, remainder=2.
REQ-036 dividend and divisor changed to random values every cycle during ITER of 1000/3 -> quotient=333, remainder=1.

Source files
------------

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Start/operand/result bundle between the calc-system control
//               unit and the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_err;

    // Control unit side: requests a division and consumes the result.
    modport master (
        output go,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  done,
        input  busy,
        input  div_err
    );

    // Divider side.
    modport slave (
        input  go,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output done,
        output busy,
        output div_err
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
//               A zero divisor completes immediately with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;      // extra bit keeps compare/subtract safe
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient in
    logic [WIDTH-1:0] dsr_q, dsr_d;      // captured divisor
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    // One restoring step on the current partial remainder / dividend pair.
    logic [2*WIDTH:0] pair_sh;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dvd;

    // Shift {rem, dvd} left, trial-subtract the divisor, restore on borrow.
    always_comb begin
        pair_sh  = {rem_q, dvd_q} << 1;
        rem_sh   = pair_sh[2*WIDTH:WIDTH];
        rem_diff = rem_sh - {1'b0, dsr_q};
        rem_ge   = (rem_sh >= {1'b0, dsr_q});
        step_rem = rem_ge ? rem_diff : rem_sh;
        step_dvd = pair_sh[WIDTH-1:0] | WIDTH'(rem_ge);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rout_d  = rout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;

        // Any edge with go low re-arms; a held-high go never restarts.
        if (!bus.go) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.go && armed_q) begin
                    dvd_d   = bus.dividend;
                    dsr_d   = bus.divisor;
                    rem_d   = '0;
                    armed_d = 1'b0;
                    if (bus.divisor == '0) begin
                        // Divide by zero: finish on the start edge itself.
                        quo_d   = '1;
                        rout_d  = bus.dividend;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH - 1);
                        busy_d  = 1'b1;
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                if (cnt_q == '0) begin
                    quo_d   = step_dvd;
                    rout_d  = step_rem[WIDTH-1:0];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rout_q  <= rout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rout_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.div_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=32) against a
//               plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: expected results and latency from the division rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic e, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; e = 1'b1; lat = 0;
        end else begin
            q = a / b; r = a % b; e = 1'b0; lat = WIDTH;
        end
    endtask

    // Pulse go for one start edge, then wait (bounded) for done.
    // lat = edges after the start edge until done is seen, -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int lat, output int bc,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic e);
        @(negedge clk);
        bus.go = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.go = 1'b0;
        lat = -1; bc = 0; q = 'x; r = 'x; e = 1'bx;
        for (int k = 0; k < 200; k++) begin
            if (bus.busy) bc++;
            if (bus.done) begin
                lat = k; q = bus.quotient; r = bus.remainder; e = bus.div_err;
                break;
            end
            if (scramble) begin
                bus.dividend = $urandom; bus.divisor = $urandom;
            end
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.go = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b err=%b, want all 0",
                     bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_err);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc; logic [31:0] q, r; logic e;
        run_op(32'd100, 32'd7, 1'b0, lat, bc, q, r, e);
        total++;
        if (lat !== 32) begin bad++; $display("FAIL basic_latency: got %0d want 32", lat); end
        total++;
        if ({q, r, e} !== {32'd14, 32'd2, 1'b0}) begin
            bad++; $display("FAIL basic_result: got q=%0d r=%0d e=%b want 14 2 0", q, r, e);
        end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle: got %b want 0", bus.done); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [31:0] q, r; logic e;
        run_op(32'd5, 32'd0, 1'b0, lat, bc, q, r, e);
        total++;
        if (lat !== 0) begin bad++; $display("FAIL divzero_latency: got %0d want 0", lat); end
        total++;
        if ({q, r, e} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            bad++; $display("FAIL divzero_result: got q=%h r=%0d e=%b want ffffffff 5 1", q, r, e);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'd3,  32'd0};
        logic [31:0] tb [3] = '{32'd1,         32'd10, 32'd9};
        for (int i = 0; i < 3; i++) begin
            int lat, bc, el; logic [31:0] q, r, eq, er; logic e, ee;
            model(ta[i], tb[i], eq, er, ee, el);
            run_op(ta[i], tb[i], 1'b0, lat, bc, q, r, e);
            total++;
            if ({lat, q, r, e} !== {el, eq, er, ee}) begin
                bad++;
                $display("FAIL boundary_%0d: got lat=%0d q=%h r=%h e=%b want lat=%0d q=%h r=%h e=%b",
                         i, lat, q, r, e, el, eq, er, ee);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int lat, bc, el; logic [31:0] a, b, q, r, eq, er; logic e, ee;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            model(a, b, eq, er, ee, el);
            run_op(a, b, 1'b0, lat, bc, q, r, e);
            total++;
            if ({lat, q, r, e} !== {el, eq, er, ee}) begin
                bad++;
                $display("FAIL random_%0d (%h/%h): got lat=%0d q=%h r=%h e=%b want lat=%0d q=%h r=%h e=%b",
                         i, a, b, lat, q, r, e, el, eq, er, ee);
            end
        end
    endtask

    task automatic test_go_held();
        int pulses;
        logic [31:0] q_seen;
        @(negedge clk);
        bus.go = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL go_held_pulses: got %0d want 1", pulses); end
        @(negedge clk); bus.go = 1'b0;
        @(negedge clk); bus.go = 1'b1;
        pulses = 0; q_seen = '0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin pulses++; q_seen = bus.quotient; end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL go_rearm_pulses: got %0d want 1", pulses); end
        total++;
        if (q_seen !== 32'd14) begin bad++; $display("FAIL go_rearm_quotient: got %0d want 14", q_seen); end
        @(negedge clk); bus.go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_iter();
        int lat, bc, pulses; logic [31:0] q, r; logic e;
        @(negedge clk);
        bus.go = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        @(negedge clk); bus.go = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_err} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got q=%h r=%h done=%b busy=%b err=%b, want all 0",
                     bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_err);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
        run_op(32'd50, 32'd6, 1'b0, lat, bc, q, r, e);
        total++;
        if ({lat, q, r, e} !== {32'd32, 32'd8, 32'd2, 1'b0}) begin
            bad++; $display("FAIL after_reset_50_6: got lat=%0d q=%0d r=%0d e=%b want 32 8 2 0", lat, q, r, e);
        end
    endtask

    task automatic test_operand_change();
        int lat, bc; logic [31:0] q, r; logic e;
        run_op(32'd1000, 32'd3, 1'b1, lat, bc, q, r, e);
        total++;
        if ({lat, q, r, e} !== {32'd32, 32'd333, 32'd1, 1'b0}) begin
            bad++; $display("FAIL operand_change: got lat=%0d q=%0d r=%0d e=%b want 32 333 1 0", lat, q, r, e);
        end
    endtask

    task automatic test_result_hold();
        int lat, bc; logic [31:0] q, r; logic e;
        run_op(32'd77, 32'd5, 1'b0, lat, bc, q, r, e);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.dividend = $urandom; bus.divisor = $urandom;
        end
        @(posedge clk); #1;
        total++;
        if ({bus.quotient, bus.remainder, bus.div_err} !== {32'd15, 32'd2, 1'b0}) begin
            bad++; $display("FAIL result_hold: got q=%0d r=%0d e=%b want 15 2 0",
                            bus.quotient, bus.remainder, bus.div_err);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_random();
        test_go_held();
        test_reset_mid_iter();
        test_operand_change();
        test_result_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
